picorv_wb_mem_responder: RTL and testbench

- Pipelined Wishbone B4 slave (responder) fronting a local single-port, byte-writable word RAM.
- It is the far end of the bus driven by the PicoRV DMA burst/single master. It serves single accesses and back-to-back 4-beat bursts.
- Configurable wait states emulate slow targets, so master stall/ack handling can be exercised.
- Out-of-window addresses complete with an error instead of an ack.

---
 rtl/picorv_wb_mem_responder_pkg.sv | 23 ++
 rtl/picorv_wb_mem_responder_if.sv | 30 +++
 rtl/picorv_wb_mem_responder_bram.sv | 30 +++
 rtl/picorv_wb_mem_responder.sv | 156 +++++++++++++++
 tb/tb_picorv_wb_mem_responder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/picorv_wb_mem_responder_pkg.sv
// Shared types and helpers for the PicoRV Wishbone memory responder.
// Holds the responder FSM encoding and the address window test.
package picorv_wb_pkg;

   typedef enum logic {
      RSP_IDLE,
      RSP_WAIT
   } rsp_state_e;

   localparam int WS_CNT_W = 4;

   // Unsigned wrap makes addresses below the base land far out of range.
   function automatic logic in_window(
      input logic [29:0] adr,
      input logic [29:0] base_w,
      input logic [29:0] words
   );
      logic [29:0] off;
      off = adr - base_w;
      return (off < words);
   endfunction

endpackage

// File: rtl/picorv_wb_mem_responder_if.sv
// Pipelined Wishbone B4 bus bundle between the DMA master and the
// memory responder.
interface picorv_wb_if;

   logic [29:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_ack_o;
   logic        wbs_stall_o;
   logic        wbs_err_o;

   modport master (
      output wbs_adr_i, wbs_dat_i, wbs_we_i,
      output wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      input  wbs_dat_o, wbs_ack_o,
      input  wbs_stall_o, wbs_err_o
   );

   modport slave (
      input  wbs_adr_i, wbs_dat_i, wbs_we_i,
      input  wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      output wbs_dat_o, wbs_ack_o,
      output wbs_stall_o, wbs_err_o
   );

endinterface

// File: rtl/picorv_wb_mem_responder_bram.sv
// Single-port word RAM with per-byte write enables and a
// one-cycle synchronous read; contents are never reset.
module picorv_wb_bram #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
               mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/picorv_wb_mem_responder.sv
// Wishbone B4 pipelined responder in front of a byte-writable RAM,
// with optional wait states and error replies outside its window.
module picorv_wb_mem_responder
   import picorv_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   picorv_wb_if.slave  wb,
   output logic [31:0] acc_cnt_o
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);
   localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
   localparam logic [29:0] DEPTH_W = 30'(MEM_WORDS);
   localparam logic [WS_CNT_W-1:0] WS_LD = WS_CNT_W'(WAIT_STATES);
   localparam logic [WS_CNT_W-1:0] CNT_ONE = WS_CNT_W'(1);
   localparam bit PIPE = (WAIT_STATES == 0);

   rsp_state_e          state_q, state_d;
   logic [WS_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [31:0]         dat_q, dat_d;
   logic [3:0]          sel_q, sel_d;
   logic                we_q, we_d;
   logic                win_q, win_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic                rd_q, rd_d;
   logic [31:0]         acc_cnt_q, acc_cnt_d;

   logic [IDX_W-1:0] idx_live;
   logic             win_live;
   logic             stall;
   logic             accept;
   logic             fire;
   logic             go, go_win, go_we;
   logic [IDX_W-1:0] go_idx;
   logic [31:0]      go_dat;
   logic [3:0]       go_sel;
   logic             ack_o, err_o;
   logic             ram_en;
   logic [3:0]       ram_we;
   logic [31:0]      ram_rdata;

   assign idx_live = IDX_W'(wb.wbs_adr_i - BASE_W);
   assign win_live = in_window(wb.wbs_adr_i, BASE_W, DEPTH_W);
   assign stall    = (state_q == RSP_WAIT);
   assign accept   = wb.wbs_cyc_i & wb.wbs_stb_i & ~stall;
   assign fire     = stall & wb.wbs_cyc_i & (cnt_q == CNT_ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RSP_IDLE;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_q      <= 1'b0;
         acc_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rd_q      <= rd_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      idx_q <= idx_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      we_q  <= we_d;
      win_q <= win_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      we_d    = we_q;
      win_d   = win_q;
      unique case (state_q)
         RSP_IDLE: begin
            if (accept && !PIPE) begin
               state_d = RSP_WAIT;
               cnt_d   = WS_LD;
               idx_d   = idx_live;
               dat_d   = wb.wbs_dat_i;
               sel_d   = wb.wbs_sel_i;
               we_d    = wb.wbs_we_i;
               win_d   = win_live;
            end
         end
         RSP_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (!wb.wbs_cyc_i || fire) begin
               state_d = RSP_IDLE;
            end
         end
         default: state_d = RSP_IDLE;
      endcase
   end

   // Pipelined mode acts on the live bus; wait mode on the latched copy.
   always_comb begin
      if (PIPE) begin
         go     = accept;
         go_win = win_live;
         go_we  = wb.wbs_we_i;
         go_idx = idx_live;
         go_dat = wb.wbs_dat_i;
         go_sel = wb.wbs_sel_i;
      end else begin
         go     = fire;
         go_win = win_q;
         go_we  = we_q;
         go_idx = idx_q;
         go_dat = dat_q;
         go_sel = sel_q;
      end
      ram_en = go & go_win & ~rst;
      ram_we = go_we ? go_sel : 4'b0000;
      ack_d  = go & go_win;
      err_d  = go & ~go_win;
      rd_d   = go & go_win & ~go_we;

      ack_o = ack_q & wb.wbs_cyc_i;
      err_o = err_q & wb.wbs_cyc_i;
      wb.wbs_ack_o   = ack_o;
      wb.wbs_err_o   = err_o;
      wb.wbs_stall_o = stall;
      wb.wbs_dat_o   = (ack_o & rd_q) ? ram_rdata : '0;

      acc_cnt_d = acc_cnt_q + 32'(ack_o | err_o);
      acc_cnt_o = acc_cnt_q;
   end

   picorv_wb_bram #(
      .DEPTH(MEM_WORDS)
   ) u_bram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (go_idx),
      .wdata(go_dat),
      .rdata(ram_rdata)
   );

endmodule

// File: tb/tb_picorv_wb_mem_responder.sv
// Bench for the Wishbone memory responder: one pipelined and one
// three-wait-state instance against a cycle-level reference model.
module tb_picorv_wb_mem_responder;

   localparam logic [31:0] BASE0 = 32'h0000_1000;
   localparam logic [31:0] BASE1 = 32'h0000_0000;
   localparam int WORDS = 16;
   localparam int WS1 = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        cyc [2];
   logic        stb [2];
   logic        we [2];
   logic [29:0] adr [2];
   logic [31:0] wdat [2];
   logic [3:0]  sel [2];

   logic        o_ack [2];
   logic        o_err [2];
   logic        o_stall [2];
   logic [31:0] o_dat [2];
   logic [31:0] o_cnt [2];

   picorv_wb_if if0 ();
   picorv_wb_if if1 ();

   assign if0.wbs_cyc_i = cyc[0];
   assign if0.wbs_stb_i = stb[0];
   assign if0.wbs_we_i  = we[0];
   assign if0.wbs_adr_i = adr[0];
   assign if0.wbs_dat_i = wdat[0];
   assign if0.wbs_sel_i = sel[0];
   assign o_ack[0]   = if0.wbs_ack_o;
   assign o_err[0]   = if0.wbs_err_o;
   assign o_stall[0] = if0.wbs_stall_o;
   assign o_dat[0]   = if0.wbs_dat_o;

   assign if1.wbs_cyc_i = cyc[1];
   assign if1.wbs_stb_i = stb[1];
   assign if1.wbs_we_i  = we[1];
   assign if1.wbs_adr_i = adr[1];
   assign if1.wbs_dat_i = wdat[1];
   assign if1.wbs_sel_i = sel[1];
   assign o_ack[1]   = if1.wbs_ack_o;
   assign o_err[1]   = if1.wbs_err_o;
   assign o_stall[1] = if1.wbs_stall_o;
   assign o_dat[1]   = if1.wbs_dat_o;

   picorv_wb_mem_responder #(
      .BASE_ADDR(BASE0), .MEM_WORDS(WORDS), .WAIT_STATES(0)
   ) dut0 (
      .clk(clk), .rst(rst), .wb(if0), .acc_cnt_o(o_cnt[0])
   );

   picorv_wb_mem_responder #(
      .BASE_ADDR(BASE1), .MEM_WORDS(WORDS), .WAIT_STATES(WS1)
   ) dut1 (
      .clk(clk), .rst(rst), .wb(if1), .acc_cnt_o(o_cnt[1])
   );

   // Reference model state, one slot per instance.
   logic [31:0] mem_m [2][WORDS];
   bit          m_pend [2];
   bit          m_ack [2];
   bit          m_err [2];
   logic [31:0] m_dat [2];
   logic [31:0] m_cnt [2];
   longint      m_due [2];
   bit          l_we [2];
   logic [29:0] l_adr [2];
   logic [31:0] l_dat [2];
   logic [3:0]  l_sel [2];
   int          ws_of [2] = '{0, WS1};
   int          base_of [2] = '{int'(BASE0 >> 2), int'(BASE1 >> 2)};
   longint      cyc_no = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_edge(input int d);
      bit fire;
      int ix;
      logic [31:0] w;
      if (rst) begin
         m_pend[d] = 1'b0;
         m_ack[d]  = 1'b0;
         m_err[d]  = 1'b0;
         m_dat[d]  = '0;
         m_cnt[d]  = '0;
         return;
      end
      if ((m_ack[d] || m_err[d]) && cyc[d]) m_cnt[d] = m_cnt[d] + 1;
      m_ack[d] = 1'b0;
      m_err[d] = 1'b0;
      m_dat[d] = '0;
      fire = 1'b0;
      if (m_pend[d]) begin
         if (!cyc[d]) m_pend[d] = 1'b0;
         else if (cyc_no == m_due[d] - 1) begin
            fire = 1'b1;
            m_pend[d] = 1'b0;
         end
      end else if (cyc[d] && stb[d]) begin
         l_we[d]  = we[d];
         l_adr[d] = adr[d];
         l_dat[d] = wdat[d];
         l_sel[d] = sel[d];
         if (ws_of[d] == 0) fire = 1'b1;
         else begin
            m_pend[d] = 1'b1;
            m_due[d]  = cyc_no + ws_of[d] + 1;
         end
      end
      if (fire) begin
         ix = int'(l_adr[d]) - base_of[d];
         if (ix < 0 || ix >= WORDS) m_err[d] = 1'b1;
         else begin
            m_ack[d] = 1'b1;
            if (l_we[d]) begin
               w = mem_m[d][ix];
               for (int k = 0; k < 4; k++)
                  if (l_sel[d][k]) w[8*k +: 8] = l_dat[d][8*k +: 8];
               mem_m[d][ix] = w;
            end else begin
               m_dat[d] = mem_m[d][ix];
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      cyc_no++;
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            bit ea, ee;
            ea = m_ack[d] && cyc[d];
            ee = m_err[d] && cyc[d];
            chk($sformatf("ack%0d", d), 32'(o_ack[d]), 32'(ea));
            chk($sformatf("err%0d", d), 32'(o_err[d]), 32'(ee));
            chk($sformatf("stall%0d", d), 32'(o_stall[d]), 32'(m_pend[d]));
            chk($sformatf("dat%0d", d), o_dat[d], ea ? m_dat[d] : 32'h0);
            chk($sformatf("cnt%0d", d), o_cnt[d], m_cnt[d]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic req(input int d, input bit w, input logic [29:0] a,
                      input logic [31:0] dt, input logic [3:0] s);
      cyc[d]  = 1'b1;
      stb[d]  = 1'b1;
      we[d]   = w;
      adr[d]  = a;
      wdat[d] = dt;
      sel[d]  = s;
   endtask

   task automatic hold(input int d);
      stb[d] = 1'b0;
      we[d]  = 1'b0;
   endtask

   task automatic idle(input int d);
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
      we[d]  = 1'b0;
   endtask

   // Single access on the wait-state instance, ending in its ack cycle.
   task automatic ws_access(input bit w, input logic [29:0] a,
                            input logic [31:0] dt);
      req(1, w, a, dt, 4'hF);
      step();
      hold(1);
      for (int k = 0; k < WS1; k++) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not reach the summary");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         idle(d);
         adr[d]  = '0;
         wdat[d] = '0;
         sel[d]  = '0;
      end
      rst = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      look();
      chk("rst_cnt0", o_cnt[0], 32'h0);
      chk("rst_ack0", 32'(o_ack[0]), 32'h0);
      chk("rst_stall1", 32'(o_stall[1]), 32'h0);

      // Write then read back, one cycle apart.
      step();
      req(0, 1'b1, 30'h400, 32'hDEADBEEF, 4'hF);
      step();
      req(0, 1'b0, 30'h400, 32'h0, 4'h0);
      look();
      chk("t1_wr_ack", 32'(o_ack[0]), 32'h1);
      chk("t1_wr_dat", o_dat[0], 32'h0);
      step();
      hold(0);
      look();
      chk("t1_rd_dat", o_dat[0], 32'hDEADBEEF);
      step();
      idle(0);
      look();
      chk("t1_cnt", o_cnt[0], 32'd2);

      // Preload words 4..7, then a back-to-back read burst.
      step();
      for (int i = 0; i < 4; i++) begin
         req(0, 1'b1, 30'(32'h404 + i), 32'(i + 1), 4'hF);
         step();
      end
      req(0, 1'b0, 30'h404, 32'h0, 4'h0);
      step();
      for (int i = 1; i <= 4; i++) begin
         if (i < 4) req(0, 1'b0, 30'(32'h404 + i), 32'h0, 4'h0);
         else hold(0);
         look();
         chk("t2_ack", 32'(o_ack[0]), 32'h1);
         chk("t2_dat", o_dat[0], 32'(i));
         chk("t2_stall", 32'(o_stall[0]), 32'h0);
         step();
      end
      idle(0);

      // Byte lanes and an empty select.
      step();
      req(0, 1'b1, 30'h408, 32'h11223344, 4'hF);
      step();
      req(0, 1'b1, 30'h408, 32'hAABBCCDD, 4'b0101);
      step();
      req(0, 1'b0, 30'h408, 32'h0, 4'h0);
      step();
      hold(0);
      look();
      chk("t3_lanes", o_dat[0], 32'h11BB33DD);
      step();
      req(0, 1'b1, 30'h408, 32'hFFFFFFFF, 4'b0000);
      step();
      req(0, 1'b0, 30'h408, 32'h0, 4'h0);
      look();
      chk("t3_sel0_ack", 32'(o_ack[0]), 32'h1);
      step();
      hold(0);
      look();
      chk("t3_sel0_keep", o_dat[0], 32'h11BB33DD);
      step();

      // Above and below the window.
      req(0, 1'b0, 30'h410, 32'h0, 4'h0);
      step();
      req(0, 1'b0, 30'h3FF, 32'h0, 4'h0);
      look();
      chk("t5_err_hi", 32'(o_err[0]), 32'h1);
      chk("t5_ack_hi", 32'(o_ack[0]), 32'h0);
      chk("t5_dat_hi", o_dat[0], 32'h0);
      step();
      hold(0);
      look();
      chk("t5_err_lo", 32'(o_err[0]), 32'h1);
      step();
      idle(0);
      look();
      chk("t5_cnt", o_cnt[0], 32'd17);

      // Strobe without cycle, then a write whose response is abandoned.
      step();
      req(0, 1'b1, 30'h408, 32'h0, 4'hF);
      cyc[0] = 1'b0;
      step();
      req(0, 1'b1, 30'h409, 32'h5A5A5A5A, 4'hF);
      look();
      chk("t6_idle_stb", 32'(o_ack[0]), 32'h0);
      step();
      idle(0);
      look();
      chk("t6_abort_ack", 32'(o_ack[0]), 32'h0);
      step();
      req(0, 1'b0, 30'h409, 32'h0, 4'h0);
      step();
      req(0, 1'b0, 30'h408, 32'h0, 4'h0);
      look();
      chk("t6_commit", o_dat[0], 32'h5A5A5A5A);
      step();
      hold(0);
      look();
      chk("t6_unchanged", o_dat[0], 32'h11BB33DD);
      step();
      idle(0);

      // Wait-state instance: preload, then stalled read with held strobe.
      ws_access(1'b1, 30'h2, 32'hCAFEF00D);
      step();
      idle(1);
      ws_access(1'b1, 30'h3, 32'h0BADF00D);
      step();
      idle(1);
      step();
      req(1, 1'b0, 30'h2, 32'h0, 4'h0);
      for (int k = 1; k <= 3; k++) begin
         step();
         look();
         chk("t4_stall", 32'(o_stall[1]), 32'h1);
         chk("t4_noack", 32'(o_ack[1]), 32'h0);
      end
      step();
      look();
      chk("t4_ack", 32'(o_ack[1]), 32'h1);
      chk("t4_stall_low", 32'(o_stall[1]), 32'h0);
      chk("t4_dat", o_dat[1], 32'hCAFEF00D);
      step();
      hold(1);
      step();
      step();
      step();
      look();
      chk("t4_ack2", 32'(o_ack[1]), 32'h1);
      chk("t4_dat2", o_dat[1], 32'hCAFEF00D);
      chk("t4_cnt", o_cnt[1], 32'd3);
      step();
      idle(1);

      // Out-of-window with wait states.
      step();
      ws_access(1'b0, 30'h10, 32'h0);
      look();
      chk("t7_err", 32'(o_err[1]), 32'h1);
      chk("t7_ack", 32'(o_ack[1]), 32'h0);
      step();
      idle(1);

      // Cycle dropped mid-wait: the write must not land.
      step();
      req(1, 1'b1, 30'h2, 32'h5555AAAA, 4'hF);
      step();
      hold(1);
      step();
      idle(1);
      for (int k = 0; k < 3; k++) begin
         look();
         chk("t8_no_rsp", 32'(o_ack[1] | o_err[1]), 32'h0);
         step();
      end
      ws_access(1'b0, 30'h2, 32'h0);
      look();
      chk("t8_old_data", o_dat[1], 32'hCAFEF00D);
      step();
      idle(1);

      // Reset while a write is waiting.
      step();
      req(1, 1'b1, 30'h3, 32'h12345678, 4'hF);
      step();
      hold(1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      look();
      chk("t9_ack", 32'(o_ack[1]), 32'h0);
      chk("t9_err", 32'(o_err[1]), 32'h0);
      chk("t9_stall", 32'(o_stall[1]), 32'h0);
      chk("t9_dat", o_dat[1], 32'h0);
      chk("t9_cnt", o_cnt[1], 32'h0);
      step();
      step();
      look();
      chk("t9_no_late_ack", 32'(o_ack[1]), 32'h0);
      step();
      idle(1);
      step();
      ws_access(1'b0, 30'h3, 32'h0);
      look();
      chk("t9_old_data", o_dat[1], 32'h0BADF00D);
      chk("t9_cnt_after", o_cnt[1], 32'h0);
      step();
      idle(1);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
